// File: rtl/tdm_burst_scheduler.sv
// Strict TDM burst scheduler: one channel is examined per cycle, and a granted channel
// streams BURST_LEN words into the shared FIFO through a registered write port.
module tdm_burst_scheduler #(
  parameter int N_CH       = 4,
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int BURST_LEN  = 4,
  parameter int GAP_CYCLES = 1,
  parameter int STALL_MAX  = 8,
  localparam int CW   = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int CNTW = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       ch_req,
  input  logic [N_CH-1:0]       ch_valid,
  input  logic [N_CH*WIDTH-1:0] ch_data,
  output logic [N_CH-1:0]       ch_ready,
  input  logic [CNTW-1:0]       fifo_count,
  output logic                  fifo_wen,
  output logic [WIDTH-1:0]      fifo_din,
  output logic                  busy,
  output logic [CW-1:0]         cur_ch,
  output logic                  burst_done,
  output logic                  burst_abort
);

  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam int SW = $clog2(STALL_MAX) + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;

  typedef enum logic [1:0] {SCAN, BURST, GAP} state_t;

  state_t             state, state_d;
  logic [CW-1:0]      ptr, ptr_d, cur_ch_d;
  logic [BW-1:0]      beat_cnt, beat_cnt_d;
  logic [SW-1:0]      stall_cnt, stall_cnt_d;
  logic [GW-1:0]      gap_cnt, gap_cnt_d;
  logic               wen_d, done_d, abort_d;
  logic [WIDTH-1:0]   din_d;

  logic [N_CH-1:0][WIDTH-1:0] ch_word;
  logic [CNTW-1:0]            free;
  logic                       grant_ok, beat;

  // ready is decoded from registered state only, so it never depends on ch_valid
  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    assign ch_word[i]  = ch_data[i*WIDTH +: WIDTH];
    assign ch_ready[i] = (state == BURST) && (cur_ch == CW'(i));
  end

  function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] p);
    return (p == CW'(N_CH - 1)) ? '0 : p + CW'(1);
  endfunction

  assign free     = CNTW'(DEPTH) - fifo_count;
  assign grant_ok = ch_req[ptr] && (free >= CNTW'(BURST_LEN));
  assign beat     = ch_valid[cur_ch] && ch_ready[cur_ch];
  assign busy     = (state != SCAN);

  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    cur_ch_d    = cur_ch;
    beat_cnt_d  = beat_cnt;
    stall_cnt_d = stall_cnt;
    gap_cnt_d   = gap_cnt;
    wen_d       = 1'b0;
    din_d       = fifo_din;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    case (state)
      SCAN: begin
        if (grant_ok) begin
          state_d     = BURST;
          cur_ch_d    = ptr;
          beat_cnt_d  = '0;
          stall_cnt_d = '0;
        end else begin
          ptr_d = wrap_inc(ptr);
        end
      end
      BURST: begin
        if (beat) begin
          wen_d       = 1'b1;
          din_d       = ch_word[cur_ch];
          beat_cnt_d  = beat_cnt + BW'(1);
          stall_cnt_d = '0;
          if (beat_cnt == BW'(BURST_LEN - 1)) begin
            state_d   = GAP;
            gap_cnt_d = '0;
            done_d    = 1'b1;
          end
        end else if (stall_cnt == SW'(STALL_MAX - 1)) begin
          state_d   = GAP;
          gap_cnt_d = '0;
          abort_d   = 1'b1;
        end else begin
          stall_cnt_d = stall_cnt + SW'(1);
        end
      end
      GAP: begin
        // restart just past the served channel so it drops to lowest priority
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          state_d = SCAN;
          ptr_d   = wrap_inc(cur_ch);
        end else begin
          gap_cnt_d = gap_cnt + GW'(1);
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SCAN;
      ptr         <= '0;
      cur_ch      <= '0;
      beat_cnt    <= '0;
      stall_cnt   <= '0;
      gap_cnt     <= '0;
      fifo_wen    <= 1'b0;
      fifo_din    <= '0;
      burst_done  <= 1'b0;
      burst_abort <= 1'b0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      cur_ch      <= cur_ch_d;
      beat_cnt    <= beat_cnt_d;
      stall_cnt   <= stall_cnt_d;
      gap_cnt     <= gap_cnt_d;
      fifo_wen    <= wen_d;
      fifo_din    <= din_d;
      burst_done  <= done_d;
      burst_abort <= abort_d;
    end
  end

endmodule

// File: tb/tb_tdm_burst_scheduler.sv
// Directed bench for tdm_burst_scheduler: per-channel counting data sources and
// cycle-exact checks sampled on the falling edge.
module tb_tdm_burst_scheduler;
  localparam int N_CH = 4;
  localparam logic [7:0] BASE [4] = '{8'h10, 8'h40, 8'hA0, 8'hC0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ch_req = '0, ch_valid = '0;
  logic [31:0] ch_data;
  logic [3:0]  ch_ready;
  logic [4:0]  fifo_count = '0;
  logic        fifo_wen;
  logic [7:0]  fifo_din;
  logic        busy;
  logic [1:0]  cur_ch;
  logic        burst_done, burst_abort;

  int ncmp = 0, nerr = 0;
  logic [7:0] idx [4];

  tdm_burst_scheduler #(.N_CH(4), .WIDTH(8), .DEPTH(16), .BURST_LEN(4),
                        .GAP_CYCLES(1), .STALL_MAX(8)) dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_ready(ch_ready), .fifo_count(fifo_count), .fifo_wen(fifo_wen),
    .fifo_din(fifo_din), .busy(busy), .cur_ch(cur_ch), .burst_done(burst_done),
    .burst_abort(burst_abort));

  always #5 clk = ~clk;

  // each source presents BASE+n for its n-th accepted word
  always @(posedge clk) begin
    for (int k = 0; k < N_CH; k++)
      if (rst) idx[k] <= 8'd0;
      else if (ch_ready[k] && ch_valid[k]) idx[k] <= idx[k] + 8'd1;
  end

  always_comb begin
    ch_data = '0;
    for (int k = 0; k < N_CH; k++) ch_data[k*8 +: 8] = BASE[k] + idx[k];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; ch_req = '0; ch_valid = '0; fifo_count = '0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  int nb, wcnt;
  int ord [5];
  int seen [4];
  logic [7:0] e;
  logic [7:0] pat;

  initial begin
    // reset state
    repeat (2) step();
    chk("rst_ready", 32'(ch_ready), 0);
    chk("rst_wen", 32'(fifo_wen), 0);
    chk("rst_din", 32'(fifo_din), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cur", 32'(cur_ch), 0);
    chk("rst_ptr", 32'(dut.ptr), 0);
    chk("rst_done_abort", 32'({burst_done, burst_abort}), 0);

    // T1: single requester ch2
    rst = 1'b0; ch_req = 4'b0100; ch_valid = 4'b0100;
    step(); chk("t1_ptr1", 32'(dut.ptr), 1); chk("t1_busy1", 32'(busy), 0);
    step(); chk("t1_ptr2", 32'(dut.ptr), 2);
    step(); chk("t1_ready", 32'(ch_ready), 4); chk("t1_cur", 32'(cur_ch), 2);
    chk("t1_busy", 32'(busy), 1); chk("t1_wen0", 32'(fifo_wen), 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) ch_req = '0;
      step();
      chk("t1_wen", 32'(fifo_wen), 1);
      chk("t1_din", 32'(fifo_din), 32'(8'hA0 + 8'(i)));
      chk("t1_done", 32'(burst_done), (i == 3) ? 1 : 0);
    end
    chk("t1_gap_busy", 32'(busy), 1); chk("t1_gap_ready", 32'(ch_ready), 0);
    step();
    chk("t1_ptr3", 32'(dut.ptr), 3); chk("t1_idle", 32'({busy, fifo_wen, burst_done}), 0);

    // T2: all requesting, round-robin 0,1,2,3,0
    do_reset();
    ch_req = 4'hF; ch_valid = 4'hF;
    nb = 0; wcnt = 0;
    for (int i = 0; i < 5; i++) ord[i] = 9;
    for (int i = 0; i < 4; i++) seen[i] = 0;
    for (int c = 0; c < 40 && nb < 5; c++) begin
      step();
      chk("t2_onehot", 32'((ch_ready & (ch_ready - 4'd1)) == 4'd0), 1);
      if (fifo_wen) begin
        e = BASE[cur_ch] + 8'(seen[cur_ch]);
        chk("t2_din", 32'(fifo_din), 32'(e));
        seen[cur_ch]++; wcnt++;
      end
      if (burst_done) begin
        chk("t2_gap_ready", 32'(ch_ready), 0);
        chk("t2_writes", 32'(wcnt), 4);
        ord[nb] = int'(cur_ch); nb++; wcnt = 0;
      end
    end
    chk("t2_bursts", 32'(nb), 5);
    for (int i = 0; i < 5; i++) chk("t2_order", 32'(ord[i]), 32'(i % 4));

    // T3: free space boundary
    do_reset();
    ch_req = 4'b0001; ch_valid = 4'b0001; fifo_count = 5'd13;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("t3_nogrant", 32'(busy), 0);
      chk("t3_ptr", 32'(dut.ptr), 32'(i % 4));
    end
    fifo_count = 5'd12;
    step(); chk("t3_ptr3", 32'(dut.ptr), 3); chk("t3_busy3", 32'(busy), 0);
    step(); chk("t3_ptr0", 32'(dut.ptr), 0); chk("t3_busy0", 32'(busy), 0);
    step(); chk("t3_grant", 32'(ch_ready), 1); chk("t3_cur", 32'(cur_ch), 0);

    // T4: stall timeout on ch1 after two beats
    do_reset();
    ch_req = 4'b0010; ch_valid = 4'b0010;
    step(); chk("t4_ptr1", 32'(dut.ptr), 1);
    step(); chk("t4_ready", 32'(ch_ready), 2);
    step(); chk("t4_w0", 32'({fifo_wen, fifo_din}), 32'({1'b1, 8'h40}));
    step(); chk("t4_w1", 32'({fifo_wen, fifo_din}), 32'({1'b1, 8'h41}));
    ch_valid = 4'b1101; ch_req = '0;
    for (int i = 5; i <= 11; i++) begin
      step();
      chk("t4_stall_wen", 32'(fifo_wen), 0);
      chk("t4_stall_pulse", 32'({burst_done, burst_abort}), 0);
      chk("t4_stall_ready", 32'(ch_ready), 2);
    end
    step();
    chk("t4_abort", 32'({burst_done, burst_abort}), 1);
    chk("t4_abort_wen", 32'(fifo_wen), 0);
    chk("t4_abort_busy", 32'(busy), 1);
    step();
    chk("t4_abort_once", 32'(burst_abort), 0);
    chk("t4_ptr2", 32'(dut.ptr), 2); chk("t4_idle", 32'(busy), 0);

    // T5: gappy valid on ch3
    do_reset();
    ch_req = 4'b1000; ch_valid = '0;
    pat = 8'b1011_0001;  // bit i = valid in burst cycle i
    repeat (4) step();
    chk("t5_ready", 32'(ch_ready), 8);
    wcnt = 0;
    for (int i = 0; i < 8; i++) begin
      ch_valid = {pat[i], 3'b000};
      step();
      chk("t5_wen", 32'(fifo_wen), 32'(pat[i]));
      if (fifo_wen) begin
        chk("t5_din", 32'(fifo_din), 32'(8'hC0 + 8'(wcnt)));
        wcnt++;
      end
      chk("t5_done", 32'(burst_done), (i == 7) ? 1 : 0);
      chk("t5_abort", 32'(burst_abort), 0);
    end
    chk("t5_writes", 32'(wcnt), 4);

    // T6: reset in the middle of a burst
    do_reset();
    ch_req = 4'b0001; ch_valid = 4'b0001;
    step(); chk("t6_grant", 32'(ch_ready), 1);
    step(); chk("t6_w0", 32'({fifo_wen, fifo_din}), 32'({1'b1, 8'h10}));
    step(); chk("t6_w1", 32'({fifo_wen, fifo_din}), 32'({1'b1, 8'h11}));
    rst = 1'b1;
    step();
    chk("t6_wen", 32'(fifo_wen), 0);
    chk("t6_ready", 32'(ch_ready), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_ptr", 32'(dut.ptr), 0);
    chk("t6_pulses", 32'({burst_done, burst_abort}), 0);
    rst = 1'b0; ch_req = '0; ch_valid = '0;
    step();
    chk("t6_post", 32'({fifo_wen, burst_done, burst_abort}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/tdm_burst_scheduler.md
Name: tdm_burst_scheduler

Overview:
- Time-division burst scheduler that shares one sync FIFO write port among N_CH requesting channels.
- Slot pointer rotates one channel per cycle. A channel is granted only if it has a burst pending and the FIFO has room for a whole burst.
- The granted channel streams BURST_LEN words into the FIFO.
- Sits between the per-channel burst sources and the shared sync FIFO; this block is the FIFO's only writer.

Parameters:
- N_CH, 4, number of requesting channels (>=2)
- WIDTH, 8, data word width
- DEPTH, 16, depth of the downstream sync FIFO
- BURST_LEN, 4, words per burst (1..DEPTH)
- GAP_CYCLES, 1, idle cycles after each burst (>=1)
- STALL_MAX, 8, consecutive no-valid cycles tolerated mid-burst before abort (>=1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- ch_req  in  N_CH  channel i has a burst pending
- ch_valid  in  N_CH  channel i data word valid
- ch_data  in  N_CH*WIDTH  channel i word at [i*WIDTH +: WIDTH]
- ch_ready  out  N_CH  one-hot accept strobe to the granted channel
- fifo_count  in  $clog2(DEPTH)+1  current FIFO occupancy
- fifo_wen  out  1  FIFO write enable
- fifo_din  out  WIDTH  FIFO write data
- busy  out  1  high in BURST and GAP
- cur_ch  out  max(1,$clog2(N_CH))  granted or last granted channel
- burst_done  out  1  one-cycle pulse, burst completed
- burst_abort  out  1  one-cycle pulse, burst terminated by stall timeout

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset:
  - state=SCAN, ptr=0, cur_ch=0, beat_cnt=0, stall_cnt=0.
  - ch_ready, fifo_wen, fifo_din, busy, burst_done and burst_abort are all 0.
- Free space: free = DEPTH - fifo_count, computed at width $clog2(DEPTH)+1 with no underflow (fifo_count <= DEPTH is guaranteed).
- SCAN state:
  - If ch_req[ptr] && free >= BURST_LEN: cur_ch<=ptr, beat_cnt<=0, stall_cnt<=0, go to BURST.
  - Otherwise ptr<=ptr+1, wrapping N_CH-1 -> 0.
  - Exactly one channel is examined per cycle (strict TDM). No look-ahead to other channels.
- BURST state:
  - ch_ready[cur_ch]=1; all other ch_ready bits are 0. ch_ready is decoded from registered state only.
  - A beat is accepted when ch_valid[cur_ch] && ch_ready[cur_ch].
  - On each beat: beat_cnt++, stall_cnt<=0.
  - On the next cycle fifo_wen=1 and fifo_din=the accepted word. Latency is exactly 1 cycle; fifo_wen is 0 otherwise.
  - Last beat (beat_cnt==BURST_LEN-1 accepted): go to GAP. burst_done is asserted in the same cycle as the last fifo_wen.
  - Cycle with no valid: stall_cnt++.
  - If stall_cnt==STALL_MAX-1 and there is still no valid: go to GAP. burst_abort pulses the next cycle. Words already written stay in the FIFO.
- GAP state:
  - Hold for GAP_CYCLES cycles, then go to SCAN with ptr<=cur_ch+1 (wrapped).
  - The just-served channel therefore gets the lowest priority, which gives round-robin fairness.
  - GAP_CYCLES>=1 guarantees the final fifo_wen is reflected in fifo_count before the next free-space check.
- Boundaries:
  - free exactly BURST_LEN: grant.
  - free==BURST_LEN-1: no grant; ptr keeps rotating.
  - ch_req deasserted during BURST: ignored; the burst still runs to completion or abort.
  - ch_valid on non-granted channels: ignored.
  - Concurrent FIFO reads only raise free space, so the check is conservative and the FIFO never overflows.
  - rst mid-burst: the burst is abandoned. The next cycle shows reset values, with no fifo_wen for a pending beat and no done/abort pulse.
  - burst_done and burst_abort are never high together.

Test Plan:
- Only ch_req[2]=1, ch_valid[2]=1, data 0xA0..0xA3, fifo_count=0 -> grant on scan cycle 2; fifo_wen high 4 consecutive cycles with A0,A1,A2,A3; burst_done coincides with A3; cur_ch=2; ptr resumes at 3.
- All four ch_req=1, valid always 1 -> grant order 0,1,2,3,0; each burst produces exactly 4 writes; at least 1 gap cycle between bursts; ch_ready always one-hot or zero.
- ch_req[0]=1, fifo_count=13 -> no grant, ptr keeps rotating; set fifo_count=12 -> grant ch0 on its next slot.
- ch1 granted, valid for 2 beats then low for 8 cycles -> exactly 2 fifo_wen; burst_abort single pulse, burst_done never asserted; next scan starts at ch2.
- ch3 granted, valid pattern 1,0,0,0,1,1,0,1 -> 4 writes in order, no abort, burst_done on the 4th write.
- rst asserted one cycle after the 2nd beat of a burst -> following cycle fifo_wen=0, ch_ready=0, busy=0, ptr=0; no burst_done or burst_abort.
